// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU types, result record and result-stage buffer states
package alu_pkg;
  localparam int XLEN_DEFAULT = 32;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR,
    OP_SAR, OP_ROL, OP_ROR, OP_MUL, OP_CMP, OP_PASS, OP_INC, OP_DEC
  } alu_op_t;
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } nzvc_t;
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] s;
    nzvc_t                   nzvc;
    alu_op_t                 op;
    logic                    hata;
  } alu_res_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;
endpackage

// File: rtl/result_skid_buf.sv
// result_skid_buf: two-entry in-order skid buffer with registered in_ready
module result_skid_buf
  import alu_pkg::*;
#(
  parameter type T = alu_res_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);
  buf_state_t state_q, state_d;
  T head_q, head_d, tail_q, tail_d;
  logic in_ready_d, push, pop;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_valid = state_q != EMPTY;
  assign out_data = head_q;
  always_comb begin
    state_d = state_q;
    head_d = head_q;
    tail_d = tail_q;
    case (state_q)
      EMPTY: begin
        state_d = push ? ONE : EMPTY;
        head_d = push ? in_data : head_q;
      end
      ONE: begin
        state_d = push && !pop ? FULL : !push && pop ? EMPTY : ONE;
        head_d = push && pop ? in_data : head_q;
        tail_d = push && !pop ? in_data : tail_q;
      end
      FULL: begin
        state_d = pop ? ONE : FULL;
        head_d = pop ? tail_q : head_q;
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = state_d != FULL;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q <= '0;
      tail_q <= '0;
      in_ready <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      in_ready <= in_ready_d;
    end
  end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: buffers ALU results and keeps flags, sticky error and counters
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int          XLEN      = XLEN_DEFAULT,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] FLAG_MASK = 16'h00FF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [XLEN-1:0]  s,
  input  logic             n,
  input  logic             z,
  input  logic             v,
  input  logic             c,
  input  logic             hata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_s,
  output logic [3:0]       out_nzvc,
  output logic [3:0]       out_op,
  output logic             out_hata,
  output logic [3:0]       flags_q,
  output logic             err_sticky,
  input  logic             err_clr,
  output logic [CNT_W-1:0] res_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  alu_res_t in_res, out_res;
  logic push, err_sticky_q, err_sticky_d;
  logic [3:0] flags_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d, err_cnt_q, err_cnt_d;
  assign in_res = {s, n, z, v, c, op, hata};
  assign {out_s, out_nzvc, out_op, out_hata} = out_res;
  assign push = in_valid & in_ready;
  assign err_sticky = err_sticky_q;
  assign res_cnt = res_cnt_q;
  assign err_cnt = err_cnt_q;
  result_skid_buf #(.T(alu_res_t)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_res),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_res)
  );
  always_comb begin
    flags_d = push && !hata && FLAG_MASK[op] ? {n, z, v, c} : flags_q;
    err_sticky_d = push && hata ? 1'b1 : err_clr ? 1'b0 : err_sticky_q;
    res_cnt_d = push && res_cnt_q != '1 ? res_cnt_q + CNT_W'(1) : res_cnt_q;
    err_cnt_d = push && hata ? (err_clr ? CNT_W'(1) : err_cnt_q == '1 ? err_cnt_q : err_cnt_q + CNT_W'(1))
                             : err_clr ? '0 : err_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      err_sticky_q <= 1'b0;
      res_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      flags_q <= flags_d;
      err_sticky_q <= err_sticky_d;
      res_cnt_q <= res_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed and random checks against a queue-based reference model
module tb_alu_result_stage;
  localparam logic [15:0] MASK = 16'h00FF;
  localparam int MAX16 = 65535;
  localparam int MAX4 = 15;
  logic clk = 1'b0, rst_n = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, hata = 1'b0, err_clr = 1'b0;
  logic n = 1'b0, z = 1'b0, v = 1'b0, c = 1'b0;
  logic [3:0] op = '0;
  logic [31:0] s = '0;
  logic in_ready, out_valid, out_hata, err_sticky;
  logic [31:0] out_s;
  logic [3:0] out_nzvc, out_op, flags_q;
  logic [15:0] res_cnt, err_cnt;
  logic sm_in_ready, sm_out_valid, sm_out_hata, sm_err_sticky;
  logic [31:0] sm_out_s;
  logic [3:0] sm_out_nzvc, sm_out_op, sm_flags_q;
  logic [3:0] sm_res_cnt, sm_err_cnt;
  typedef struct {
    logic [31:0] s;
    logic [3:0]  f;
    logic [3:0]  op;
    logic        h;
  } ent_t;
  ent_t q[$];
  int vecs = 0, errs = 0;
  int m_res, m_err, s_res, s_err;
  bit m_st, m_rdy;
  logic [3:0] m_flags;
  always #5 clk = ~clk;
  alu_result_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .s(s),
    .n(n), .z(z), .v(v), .c(c), .hata(hata), .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_nzvc(out_nzvc), .out_op(out_op), .out_hata(out_hata), .flags_q(flags_q),
    .err_sticky(err_sticky), .err_clr(err_clr), .res_cnt(res_cnt), .err_cnt(err_cnt)
  );
  alu_result_stage #(.CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sm_in_ready), .op(op), .s(s),
    .n(n), .z(z), .v(v), .c(c), .hata(hata), .out_valid(sm_out_valid), .out_ready(out_ready),
    .out_s(sm_out_s), .out_nzvc(sm_out_nzvc), .out_op(sm_out_op), .out_hata(sm_out_hata),
    .flags_q(sm_flags_q), .err_sticky(sm_err_sticky), .err_clr(err_clr), .res_cnt(sm_res_cnt),
    .err_cnt(sm_err_cnt)
  );
  function automatic int sat(input int x, input int mx);
    return x > mx ? mx : x;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("out_s", out_s, q[0].s);
      chk("out_nzvc", {28'd0, out_nzvc}, {28'd0, q[0].f});
      chk("out_op", {28'd0, out_op}, {28'd0, q[0].op});
      chk("out_hata", {31'd0, out_hata}, {31'd0, q[0].h});
    end
    chk("flags_q", {28'd0, flags_q}, {28'd0, m_flags});
    chk("err_sticky", {31'd0, err_sticky}, {31'd0, m_st});
    chk("res_cnt", {16'd0, res_cnt}, m_res);
    chk("err_cnt", {16'd0, err_cnt}, m_err);
    chk("res_cnt_w4", {28'd0, sm_res_cnt}, s_res);
    chk("err_cnt_w4", {28'd0, sm_err_cnt}, s_err);
  endtask
  task automatic cyc(input bit iv, input bit ordy, input logic [3:0] o, input logic [31:0] sv,
                     input logic [3:0] f, input bit h, input bit clr);
    bit push, pop;
    in_valid = iv;
    out_ready = ordy;
    op = iv ? o : 4'bx;
    s = iv ? sv : 32'bx;
    {n, z, v, c} = f;
    hata = h;
    err_clr = clr;
    @(posedge clk);
    push = iv && m_rdy;
    pop = q.size() != 0 && ordy;
    if (pop) q.delete(0);
    if (push) q.push_back('{s: sv, f: f, op: o, h: h});
    if (push && !h && MASK[o]) m_flags = f;
    if (push) begin
      m_res = sat(m_res + 1, MAX16);
      s_res = sat(s_res + 1, MAX4);
    end
    if (push && h) begin
      m_st = 1'b1;
      m_err = clr ? 1 : sat(m_err + 1, MAX16);
      s_err = clr ? 1 : sat(s_err + 1, MAX4);
    end else if (clr) begin
      m_st = 1'b0;
      m_err = 0;
      s_err = 0;
    end
    m_rdy = q.size() < 2;
    @(negedge clk);
    check_all();
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_res_cnt", {16'd0, res_cnt}, 32'd0);
    chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("rst_out_s", out_s, 32'd0);
    chk("rst_flags", {28'd0, flags_q}, 32'd0);
    chk("rst_sticky", {31'd0, err_sticky}, 32'd0);
    q.delete();
    m_res = 0; m_err = 0; s_res = 0; s_err = 0;
    m_st = 1'b0; m_rdy = 1'b0; m_flags = 4'd0;
    in_valid = 1'b0;
    err_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_in_ready", {31'd0, in_ready}, 32'd0);
    cyc(0, 1, 0, 0, 0, 0, 0);
  endtask
  initial begin
    do_reset();
    cyc(1, 1, 4'd0, 32'd5, 4'b0000, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 4'd1, 32'd1, 4'b0001, 0, 0);
    cyc(1, 0, 4'd2, 32'd2, 4'b0010, 0, 0);
    cyc(1, 0, 4'd3, 32'd3, 4'b0011, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 4'd4, 32'd4, 4'b0100, 0, 0);
    cyc(1, 0, 4'd5, 32'd5, 4'b0101, 0, 0);
    do_reset();
    for (int i = 0; i < 100; i++) cyc(1, 1, 4'(i), 32'(i), 4'(i), 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 4'd7, 32'hA, 4'b1001, 0, 0);
    cyc(1, 1, 4'd9, 32'hB, 4'b0110, 0, 0);
    cyc(1, 1, 4'd15, 32'hC, 4'b0110, 0, 0);
    cyc(1, 1, 4'd3, 32'hD, 4'b1111, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 1);
    repeat (2) cyc(1, 1, 4'd2, 32'hE, 4'b0101, 1, 0);
    cyc(1, 1, 4'd2, 32'hF, 4'b0101, 1, 1);
    for (int i = 0; i < 20; i++) cyc(1, 1, 4'd1, 32'(i), 4'b1010, 1, 0);
    cyc(1, 0, 4'd6, 32'h11, 4'b0011, 0, 1);
    cyc(1, 0, 4'd6, 32'h12, 4'b1100, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 4'($urandom), $urandom,
          4'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
